// File: rtl/updown_pkg.sv
// Shared types for the up/down count decoder.
// State enum, count encodings, delta classes, default width.
package updown_pkg;

  localparam int POS_W_DEF = 8;

  localparam logic [1:0] C0 = 2'd0;
  localparam logic [1:0] C1 = 2'd1;
  localparam logic [1:0] C2 = 2'd2;
  localparam logic [1:0] C3 = 2'd3;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    D_HOLD = 2'd0,
    D_UP   = 2'd1,
    D_JUMP = 2'd2,
    D_DOWN = 2'd3
  } delta_e;

endpackage

// File: rtl/updown_delta.sv
// Classifies the modulo-4 difference between the new and last
// count sample as hold, up, down or illegal jump.
module updown_delta
  import updown_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic [1:0] last_i,
  output delta_e     cls_o
);

  logic [1:0] diff;

  assign diff = cnt_i - last_i;

  // Map the wrapped difference onto a movement class.
  always_comb begin
    cls_o = D_HOLD;
    unique case (1'b1)
      (diff == C0): cls_o = D_HOLD;
      (diff == C1): cls_o = D_UP;
      (diff == C2): cls_o = D_JUMP;
      (diff == C3): cls_o = D_DOWN;
      default:      cls_o = D_HOLD;
    endcase
  end

endmodule

// File: rtl/updown_decoder.sv
// Up/down count decoder: step/dir/err pulses, position, lock FSM.
// Optional error counter: define UPDOWN_DECODER_ERRCNT_EN.
module updown_decoder
  import updown_pkg::*;
#(
  parameter int POS_W = POS_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       CNT_IN,
  output logic             Step,
  output logic             Dir,
  output logic             Err,
  output logic             Locked,
  output logic [POS_W-1:0] POS,
  output logic [3:0]       ErrCnt
);

  state_e           state_q, state_d;
  logic [1:0]       last_q;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             stab_q, stab_d;
  delta_e           cls;

  updown_delta u_delta (
    .cnt_i  (CNT_IN),
    .last_i (last_q),
    .cls_o  (cls)
  );

  // Next state, pulses and position from the delta class.
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    dir_d   = dir_q;
    pos_d   = pos_q;
    stab_d  = stab_q;
    unique case (state_q)
      S_INIT: begin
        state_d = S_TRACK;
        stab_d  = 1'b0;
      end
      S_TRACK: begin
        unique case (cls)
          D_UP: begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            pos_d  = pos_q + POS_W'(1);
          end
          D_DOWN: begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            pos_d  = pos_q - POS_W'(1);
          end
          D_JUMP: begin
            err_d   = 1'b1;
            state_d = S_FAULT;
            stab_d  = 1'b0;
          end
          default: ;
        endcase
      end
      S_FAULT: begin
        unique case (cls)
          D_HOLD: begin
            if (stab_q) begin
              state_d = S_TRACK;
              stab_d  = 1'b0;
            end else begin
              stab_d = 1'b1;
            end
          end
          D_JUMP: begin
            err_d  = 1'b1;
            stab_d = 1'b0;
          end
          default: stab_d = 1'b0;
        endcase
      end
      default: begin
        state_d = S_INIT;
        stab_d  = 1'b0;
      end
    endcase
  end

  // State, last sample and registered outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_INIT;
      last_q  <= C0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= '0;
      stab_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= CNT_IN;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      pos_q   <= pos_d;
      stab_q  <= stab_d;
    end
  end

  assign Step   = step_q;
  assign Dir    = dir_q;
  assign Err    = err_q;
  assign POS    = pos_q;
  assign Locked = (state_q == S_TRACK);

`ifdef UPDOWN_DECODER_ERRCNT_EN
  logic [3:0] ecnt_q, ecnt_d;

  // Saturating count, updated alongside the Err register.
  always_comb begin
    ecnt_d = ecnt_q;
    if (err_d && (ecnt_q != 4'hF)) ecnt_d = ecnt_q + 4'd1;
  end

  // Error counter register; cleared only by reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) ecnt_q <= 4'd0;
    else        ecnt_q <= ecnt_d;
  end

  assign ErrCnt = ecnt_q;
`else
  assign ErrCnt = 4'd0;
`endif

endmodule
